// File: rtl/pipe_share_arb_if.sv
// rtl/pipe_share_arb_if.sv - request, pipeline, response and counter bundle for pipe_share_arb
//
// Purpose: groups every non-clock/reset signal of pipe_share_arb.
// Modports:
//   slave  - the arbiter side (pipe_share_arb).
//   master - the requesters + shared pipeline + debug observer side.
// Signals:
//   req0/1_valid, req0/1_data  requester payloads; req0/1_ready grant strobes
//   pipe_din / pipe_dout        shared fixed-latency pipeline input / result
//   rsp0/1_valid, rsp_data      routed responses on one shared bus
//   busy                        at least one word in flight
//   cnt_clr, gnt_cnt0/1         saturating grant counters and their clear
interface pipe_share_arb_if #(
  parameter int WIDTH = 6,
  parameter int CNTW  = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic [WIDTH-1:0] pipe_din;
  logic [WIDTH-1:0] pipe_dout;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             cnt_clr;
  logic [CNTW-1:0]  gnt_cnt0;
  logic [CNTW-1:0]  gnt_cnt1;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, pipe_dout, cnt_clr,
    output req0_ready, req1_ready, pipe_din, rsp0_valid, rsp1_valid, rsp_data,
           busy, gnt_cnt0, gnt_cnt1
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, pipe_dout, cnt_clr,
    input  req0_ready, req1_ready, pipe_din, rsp0_valid, rsp1_valid, rsp_data,
           busy, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/pipe_share_arb.sv
// rtl/pipe_share_arb.sv - round-robin sharing of one fixed-latency pipeline between two requesters
//
// Purpose: each cycle grants at most one of two requesters (round-robin on
// contention), drives its data into an external non-stallable pipeline of
// latency LAT, and routes the result back to the right requester LAT cycles
// later using a tag shift register. Keeps saturating per-requester grant counts.
// Ports:
//   clk    rising-edge clock
//   rst_l  asynchronous active-low reset
//   bus    pipe_share_arb_if.slave (requests, pipeline, responses, counters)
module pipe_share_arb #(
  parameter int WIDTH = 6,
  parameter int LAT   = 2,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_l,
  pipe_share_arb_if.slave bus
);

  logic            r_last_gnt;  // 1 = requester 1 was granted last
  logic [LAT-1:0]  r_tag_vld;
  logic [LAT-1:0]  r_tag_id;
  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;
  logic w_out_vld;
  logic w_out_id;

  // On contention the requester that did not win last time is granted.
  // Grants are held off while reset is asserted so no handshake can
  // complete into a pipeline whose tags are being cleared.
  assign w_gnt0    = rst_l & bus.req0_valid & (~bus.req1_valid | r_last_gnt);
  assign w_gnt1    = rst_l & bus.req1_valid & (~bus.req0_valid | ~r_last_gnt);
  assign w_gnt_any = w_gnt0 | w_gnt1;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.pipe_din   = w_gnt0 ? bus.req0_data :
                          w_gnt1 ? bus.req1_data : '0;

  // Tag k describes the word that entered the pipeline k+1 cycles ago,
  // so the last stage lines up with pipe_dout.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_last_gnt <= 1'b1;
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
    end else begin
      if (w_gnt_any) begin
        r_last_gnt <= w_gnt1;
      end
      r_tag_vld[0] <= w_gnt_any;
      r_tag_id[0]  <= w_gnt1;
      for (int k = 1; k < LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  assign w_out_vld = r_tag_vld[LAT-1];
  assign w_out_id  = r_tag_id[LAT-1];

  assign bus.rsp0_valid = w_out_vld & ~w_out_id;
  assign bus.rsp1_valid = w_out_vld &  w_out_id;
  assign bus.rsp_data   = w_out_vld ? bus.pipe_dout : '0;
  assign bus.busy       = |r_tag_vld;

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_cnt0 != {CNTW{1'b1}})) begin
        r_cnt0 <= r_cnt0 + CNTW'(1);
      end
      if (w_gnt1 && (r_cnt1 != {CNTW{1'b1}})) begin
        r_cnt1 <= r_cnt1 + CNTW'(1);
      end
    end
  end

  assign bus.gnt_cnt0 = r_cnt0;
  assign bus.gnt_cnt1 = r_cnt1;

endmodule
